// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
//   arb_state_t : arbiter FSM state (IDLE / OWN)
//   N_REQ       : number of requesters
//   SEL_W       : width of the mux select / requester index
//   onehot2()   : requester index -> one-hot grant vector
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] s);
        return N_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin picker.
//   req   in  4  request vector
//   last  in  2  most recent owner; search starts at last+1 and wraps
//   mask  in  4  1 = requester eligible (clears the current owner)
//   found out 1  some eligible requester exists
//   pick  out 2  index of the first eligible requester after last
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] pick
);

    logic [N_REQ-1:0] elig;

    assign elig = req & mask;

    always_comb begin
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        // Offsets 1..N_REQ; offset N_REQ lands back on last itself.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/mux4to1.sv
// Gate-level 4-to-1 multiplexer in the ALU datapath.
//   d   in  4  data inputs
//   sel in  2  select
//   y   out 1  d[sel]
module mux4to1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    logic s0_n;
    logic s1_n;
    logic [3:0] term;

    assign s0_n = ~sel[0];
    assign s1_n = ~sel[1];

    assign term[0] = d[0] & s1_n   & s0_n;
    assign term[1] = d[1] & s1_n   & sel[0];
    assign term[2] = d[2] & sel[1] & s0_n;
    assign term[3] = d[3] & sel[1] & sel[0];

    assign y = term[0] | term[1] | term[2] | term[3];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4-to-1 ALU mux.
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   req    in  4  per-requester request, held high until done
//   grant  out 4  registered one-hot owner, 0000 when idle
//   sel    out 2  registered mux select, tracks the owner
//   busy   out 1  |grant
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             found;
    logic [SEL_W-1:0] pick;
    logic             owner_req;

    // Masking the current grant serves both cases: in IDLE grant is 0, and in
    // OWN the owner is excluded (on release its req is already low anyway).
    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .mask  (~grant_q),
        .found (found),
        .pick  (pick)
    );

    assign owner_req = |(req & grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= '1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    grant_d = onehot2(pick);
                    sel_d   = pick;
                    last_d  = pick;
                    hold_d  = '0;
                end
            end

            OWN: begin
                // >= rather than == so a requester arriving after the counter
                // has saturated still preempts the owner on the next edge.
                if (!owner_req || (hold_q >= HOLD_LAST && found)) begin
                    if (found) begin
                        grant_d = onehot2(pick);
                        sel_d   = pick;
                        last_d  = pick;
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = |grant_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] mux_in = 4'b1010;
    logic       mux_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .busy  (busy)
    );

    mux4to1 u_mux (
        .d   (mux_in),
        .sel (sel),
        .y   (mux_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] es);
        logic eb;
        logic em;
        eb = |eg;
        em = mux_in[es];
        n_cmp++;
        assert (grant === eg) else begin
            n_bad++;
            $error("FAIL %s grant: got %b expected %b", tag, grant, eg);
        end
        n_cmp++;
        assert (sel === es) else begin
            n_bad++;
            $error("FAIL %s sel: got %b expected %b", tag, sel, es);
        end
        n_cmp++;
        assert (busy === eb) else begin
            n_bad++;
            $error("FAIL %s busy: got %b expected %b", tag, busy, eb);
        end
        n_cmp++;
        assert (mux_out === em) else begin
            n_bad++;
            $error("FAIL %s mux_out: got %b expected %b", tag, mux_out, em);
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic pulse_reset(input logic [3:0] new_req);
        rst_n = 1'b0;
        req   = new_req;
        #2;
        check("async_rst", 4'b0000, 2'b00);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset state, then req0 wins first (pointer starts at 3)
        rst_n = 1'b0;
        req   = 4'b1111;
        #3;
        check("t1_rst", 4'b0000, 2'b00);
        tick();
        check("t1_rst_held", 4'b0000, 2'b00);
        rst_n = 1'b1;
        tick();
        check("t1_first", 4'b0001, 2'b00);

        // 2: single requester 2, then release to idle; sel holds
        tick();
        pulse_reset(4'b0100);
        tick();
        check("t2_c1", 4'b0100, 2'b10);
        tick();
        check("t2_c2", 4'b0100, 2'b10);
        tick();
        check("t2_c3", 4'b0100, 2'b10);
        req = 4'b0000;
        tick();
        check("t2_idle", 4'b0000, 2'b10);

        // 3: all requesting, 8-cycle quantum, pointer wraps 3->0
        pulse_reset(4'b0000);
        req = 4'b1111;
        for (int i = 1; i <= 40; i++) begin
            logic [1:0] own;
            tick();
            own = 2'((i - 1) / 8);
            check($sformatf("t3_c%0d", i), 4'b0001 << own, own);
        end

        // 4: release hands over directly with no idle cycle
        tick();
        pulse_reset(4'b0101);
        tick();
        check("t4_c1", 4'b0001, 2'b00);
        tick();
        check("t4_c2", 4'b0001, 2'b00);
        req = 4'b0100;
        tick();
        check("t4_handover", 4'b0100, 2'b10);

        // 5: sole requester is never preempted
        pulse_reset(4'b0001);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("t5_c%0d", i), 4'b0001, 2'b00);
        end

        // 6: reset mid-grant, pointer returns to 3
        pulse_reset(4'b1000);
        tick();
        check("t6_own3", 4'b1000, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_midrst", 4'b0000, 2'b00);
        req   = 4'b1010;
        rst_n = 1'b1;
        tick();
        check("t6_after", 4'b0010, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
